sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/fifo_pkg.sv | 11 +
 rtl/sync_fifo_if.sv | 25 ++
 rtl/fifo_ram.sv | 19 +
 rtl/sync_fifo.sv | 60 ++++++
 tb/tb_sync_fifo.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: depth/pointer-width derivations and default widths shared by the FIFO variants
package fifo_pkg;
    localparam int default_data_width = 32;
    localparam int default_address_width = 4;
    function automatic int fifo_depth(input int address_width);
        return 1 << address_width;
    endfunction
    function automatic int ptr_width(input int address_width);
        return address_width + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: push/pop handshake, read data and status flags of a sync_fifo
interface sync_fifo_if #(
    parameter int data_width = 32,
    parameter int address_width = 4
);
    logic wr;
    logic rd;
    logic [data_width-1:0] write_data;
    logic [data_width-1:0] read_data;
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic [address_width:0] count;
    logic overflow;
    logic underflow;
    modport master (
        output wr, rd, write_data,
        input read_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input wr, rd, write_data,
        output read_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// fifo_ram: single-clock dual-port storage, synchronous write and asynchronous read, no reset
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int data_width = default_data_width,
    parameter int address_width = default_address_width
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [address_width-1:0] waddr,
    input  logic [data_width-1:0]    wdata,
    input  logic [address_width-1:0] raddr,
    output logic [data_width-1:0]    rdata
);
    logic [data_width-1:0] mem [fifo_depth(address_width)];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers, registered or first-word-fall-through read
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int data_width = default_data_width,
    parameter int address_width = default_address_width,
    parameter int almost_full_level = fifo_depth(address_width) - 2,
    parameter int almost_empty_level = 2,
    parameter bit fwft = 1'b0
) (
    input logic        clk,
    input logic        rst,
    sync_fifo_if.slave bus
);
    localparam int pw = ptr_width(address_width);
    localparam logic [pw-1:0] depth_c = pw'(fifo_depth(address_width));
    localparam logic [pw-1:0] af_c = pw'(almost_full_level);
    localparam logic [pw-1:0] ae_c = pw'(almost_empty_level);
    logic [pw-1:0] wr_ptr, rd_ptr, count;
    logic [data_width-1:0] head, read_q;
    logic full, empty, wr_ok, rd_ok, overflow, underflow;
    // flags come from the count register only, never from rd/wr
    assign full = count == depth_c;
    assign empty = count == '0;
    assign wr_ok = bus.wr && (!full || bus.rd);
    assign rd_ok = bus.rd && !empty;
    fifo_ram #(.data_width(data_width), .address_width(address_width)) u_ram (
        .clk  (clk),
        .we   (wr_ok && !rst),
        .waddr(wr_ptr[address_width-1:0]),
        .wdata(bus.write_data),
        .raddr(rd_ptr[address_width-1:0]),
        .rdata(head)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
            read_q <= '0;
        end else begin
            wr_ptr <= wr_ptr + pw'(wr_ok);
            rd_ptr <= rd_ptr + pw'(rd_ok);
            count <= count + pw'(wr_ok) - pw'(rd_ok);
            overflow <= bus.wr && full && !bus.rd;
            underflow <= bus.rd && empty;
            if (rd_ok) read_q <= head;
        end
    end
    assign bus.read_data = fwft ? head : read_q;
    assign bus.full = full;
    assign bus.empty = empty;
    assign bus.almost_full = count >= af_c;
    assign bus.almost_empty = count <= ae_c;
    assign bus.count = count;
    assign bus.overflow = overflow;
    assign bus.underflow = underflow;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: registered and FWFT FIFOs driven in lockstep, checked against a queue model
module tb_sync_fifo;
    localparam int depth = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    sync_fifo_if #(.data_width(32), .address_width(4)) bus0 ();
    sync_fifo_if #(.data_width(32), .address_width(4)) bus1 ();
    sync_fifo #(.fwft(1'b0)) u0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    sync_fifo #(.fwft(1'b1)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    logic [31:0] model_q[$];
    logic [31:0] exp_q[$];
    logic exp_ovf = 1'b0;
    logic exp_udf = 1'b0;
    logic mon_en = 1'b0;
    int checks = 0;
    int errors = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step(input logic w, input logic r, input logic [31:0] d, input logic rs);
        int n;
        @(negedge clk);
        rst = rs;
        bus0.wr = w; bus1.wr = w;
        bus0.rd = r; bus1.rd = r;
        bus0.write_data = d; bus1.write_data = d;
        if (rs) begin
            mon_en = 1'b1;
            model_q.delete();
            exp_q.delete();
            exp_q.push_back(32'h0);
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            n = model_q.size();
            exp_ovf = w && n == depth && !r;
            exp_udf = r && n == 0;
            if (r && n > 0) exp_q.push_back(model_q.pop_front());
            if (w && (n < depth || r)) model_q.push_back(d);
        end
        @(posedge clk);
        #2;
    endtask
    task automatic flags(input string tag, input logic [4:0] cnt, input logic f, input logic e,
                         input logic af, input logic ae, input logic ov, input logic ud);
        int n;
        n = model_q.size();
        check({tag, " count"}, 32'(cnt), 32'(n));
        check({tag, " full"}, 32'(f), 32'(n == depth));
        check({tag, " empty"}, 32'(e), 32'(n == 0));
        check({tag, " almost_full"}, 32'(af), 32'(n >= depth - 2));
        check({tag, " almost_empty"}, 32'(ae), 32'(n <= 2));
        check({tag, " overflow"}, 32'(ov), 32'(exp_ovf));
        check({tag, " underflow"}, 32'(ud), 32'(exp_udf));
    endtask
    // monitor: one popped word is presented per accepted read, FWFT always shows the head
    initial begin
        logic [31:0] last;
        last = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                flags("u0", bus0.count, bus0.full, bus0.empty, bus0.almost_full,
                      bus0.almost_empty, bus0.overflow, bus0.underflow);
                flags("u1", bus1.count, bus1.full, bus1.empty, bus1.almost_full,
                      bus1.almost_empty, bus1.overflow, bus1.underflow);
                if (exp_q.size() > 0) last = exp_q.pop_front();
                check("u0 read_data", bus0.read_data, last);
                if (model_q.size() > 0) check("u1 head", bus1.read_data, model_q[0]);
            end
        end
    end
    initial begin
        logic w, r, rs;
        bus0.wr = 0; bus0.rd = 0; bus0.write_data = 0;
        bus1.wr = 0; bus1.rd = 0; bus1.write_data = 0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("reset empty", 32'(bus0.empty), 1);
        check("reset almost_empty", 32'(bus0.almost_empty), 1);
        check("reset full", 32'(bus0.full), 0);
        check("reset almost_full", 32'(bus0.almost_full), 0);
        check("reset count", 32'(bus0.count), 0);
        check("reset read_data", bus0.read_data, 0);
        for (int k = 0; k < 15; k++) begin
            step(1, 0, 32'h11 + 32'(k), 0);
            if (k == 12) check("af below level", 32'(bus0.almost_full), 0);
            if (k == 13) check("af at 14", 32'(bus0.almost_full), 1);
        end
        step(1, 0, 32'h20, 0);
        check("full after 16", 32'(bus0.full), 1);
        check("count after 16", 32'(bus0.count), 16);
        step(1, 0, 32'hDEAD, 0);
        check("overflow pulse", 32'(bus0.overflow), 1);
        check("overflow count", 32'(bus0.count), 16);
        step(0, 0, 0, 0);
        check("overflow drop", 32'(bus0.overflow), 0);
        step(1, 1, 32'hBEEF, 0);
        check("full rdwr data", bus0.read_data, 32'h11);
        check("full rdwr count", 32'(bus0.count), 16);
        for (int k = 0; k < 16; k++) begin
            step(0, 1, 0, 0);
            if (k == 14) check("fwft head beef", bus1.read_data, 32'hBEEF);
        end
        check("beef out", bus0.read_data, 32'hBEEF);
        check("drained", 32'(bus0.count), 0);
        step(0, 1, 0, 0);
        check("underflow pulse", 32'(bus0.underflow), 1);
        check("underflow count", 32'(bus0.count), 0);
        check("underflow hold", bus0.read_data, 32'hBEEF);
        step(0, 0, 0, 0);
        check("underflow drop", 32'(bus0.underflow), 0);
        step(1, 0, 32'hA5, 0);
        check("fwft not empty", 32'(bus1.empty), 0);
        check("fwft a5", bus1.read_data, 32'hA5);
        step(0, 1, 0, 0);
        check("fwft empty again", 32'(bus1.empty), 1);
        step(1, 1, 32'h77, 0);
        check("empty rdwr underflow", 32'(bus0.underflow), 1);
        check("empty rdwr count", 32'(bus0.count), 1);
        check("empty rdwr fwft", bus1.read_data, 32'h77);
        step(1, 1, 32'h88, 0);
        check("single rdwr count", 32'(bus0.count), 1);
        check("single rdwr data", bus0.read_data, 32'h77);
        check("single rdwr head", bus1.read_data, 32'h88);
        // alternate write-heavy and read-heavy phases to hit full, empty and pointer wrap
        for (int i = 0; i < 10000; i++) begin
            w = $urandom_range(99) < (((i / 400) % 2) == 0 ? 75 : 30);
            r = $urandom_range(99) < (((i / 400) % 2) == 0 ? 30 : 75);
            rs = $urandom_range(999) == 0;
            step(w, r, $urandom, rs);
        end
        step(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
